// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target that ACKs SLAVE_ADDR, accepts a two-byte
// write word and returns a two-byte read word. It oversamples sclk/sda on clk
// and drives sda open-drain (pull low or release).
// Optional build macro I2C_GLITCH_FILTER_EN inserts a 3-sample majority
// filter after the synchronizers on both bus lines.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h27,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  inout  wire         sda,
  input  logic [15:0] tx_data,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        done,
  output logic        nack_seen
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_ADDR,
    S_WR_BYTE,
    S_ACK_WR,
    S_RD_BYTE,
    S_ACK_RD,
    S_WAIT_STOP
  } state_t;

  // Synchronizers idle high so a reset never creates a false bus event
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   w_sclk_f;
  logic                   w_sda_f;
  logic                   r_sclk_prev;
  logic                   r_sda_prev;

  // Bring the asynchronous bus lines into the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= '1;
      r_sda_sync  <= '1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], sda};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] r_sclk_hist;
  logic [2:0] r_sda_hist;

  // Keep the last three synchronized samples for the majority vote
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_hist <= 3'b111;
      r_sda_hist  <= 3'b111;
    end else begin
      r_sclk_hist <= {r_sclk_hist[1:0], r_sclk_sync[SYNC_STAGES-1]};
      r_sda_hist  <= {r_sda_hist[1:0], r_sda_sync[SYNC_STAGES-1]};
    end
  end

  assign w_sclk_f = (r_sclk_hist[0] & r_sclk_hist[1]) |
                    (r_sclk_hist[0] & r_sclk_hist[2]) |
                    (r_sclk_hist[1] & r_sclk_hist[2]);
  assign w_sda_f  = (r_sda_hist[0] & r_sda_hist[1]) |
                    (r_sda_hist[0] & r_sda_hist[2]) |
                    (r_sda_hist[1] & r_sda_hist[2]);
`else
  assign w_sclk_f = r_sclk_sync[SYNC_STAGES-1];
  assign w_sda_f  = r_sda_sync[SYNC_STAGES-1];
`endif

  // Previous sample of each line, used for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_prev <= 1'b1;
      r_sda_prev  <= 1'b1;
    end else begin
      r_sclk_prev <= w_sclk_f;
      r_sda_prev  <= w_sda_f;
    end
  end

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_start;
  logic w_stop;

  assign w_sclk_rise = w_sclk_f & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_f & r_sclk_prev;
  assign w_start     = w_sclk_f & r_sclk_prev & ~w_sda_f & r_sda_prev;
  assign w_stop      = w_sclk_f & r_sclk_prev & w_sda_f & ~r_sda_prev;

  // Transaction state and datapath registers
  state_t      r_state,     w_state_nxt;
  logic        r_sda_drv,   w_sda_drv_nxt;
  logic [3:0]  r_bit_cnt,   w_bit_cnt_nxt;
  logic [7:0]  r_shift,     w_shift_nxt;
  logic        r_rw,        w_rw_nxt;
  logic        r_ack_ph,    w_ack_ph_nxt;
  logic [1:0]  r_byte_idx,  w_byte_idx_nxt;
  logic [15:0] r_shadow,    w_shadow_nxt;
  logic [7:0]  r_rx_hi,     w_rx_hi_nxt;
  logic [15:0] r_rx_data,   w_rx_data_nxt;
  logic        r_rx_valid,  w_rx_valid_nxt;
  logic        r_busy,      w_busy_nxt;
  logic        r_done,      w_done_nxt;
  logic        r_nack_seen, w_nack_seen_nxt;

  // Open-drain pin: pull low or release to the bus pull-up
  assign sda       = r_sda_drv ? 1'b0 : 1'bz;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign nack_seen = r_nack_seen;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers; reset releases sda immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sda_drv   <= 1'b0;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'd0;
      r_rw        <= 1'b0;
      r_ack_ph    <= 1'b0;
      r_byte_idx  <= 2'd0;
      r_shadow    <= 16'd0;
      r_rx_hi     <= 8'd0;
      r_rx_data   <= 16'd0;
      r_rx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_nack_seen <= 1'b0;
    end else begin
      r_sda_drv   <= w_sda_drv_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_rw        <= w_rw_nxt;
      r_ack_ph    <= w_ack_ph_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_shadow    <= w_shadow_nxt;
      r_rx_hi     <= w_rx_hi_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_nack_seen <= w_nack_seen_nxt;
    end
  end

  // Next-state and output decode; START/STOP override any bit activity
  always_comb begin
    w_state_nxt     = r_state;
    w_sda_drv_nxt   = r_sda_drv;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_rw_nxt        = r_rw;
    w_ack_ph_nxt    = r_ack_ph;
    w_byte_idx_nxt  = r_byte_idx;
    w_shadow_nxt    = r_shadow;
    w_rx_hi_nxt     = r_rx_hi;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_nack_seen_nxt = r_nack_seen;

    if (w_stop) begin
      w_state_nxt   = S_IDLE;
      w_sda_drv_nxt = 1'b0;
      w_done_nxt    = r_busy;
      w_busy_nxt    = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_bit_cnt_nxt = 4'd0;
      w_sda_drv_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_sda_drv_nxt = 1'b0;
        end

        S_ADDR: begin
          if (w_sclk_rise) begin
            w_shift_nxt   = {r_shift[6:0], w_sda_f};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_bit_cnt_nxt = 4'd0;
              w_rw_nxt      = w_sda_f;
              w_ack_ph_nxt  = 1'b0;
              // The first seven bits shifted in are the address
              if (r_shift[6:0] == SLAVE_ADDR) begin
                w_state_nxt = S_ACK_ADDR;
              end else begin
                w_state_nxt = S_WAIT_STOP;
              end
            end
          end
        end

        S_ACK_ADDR: begin
          if (w_sclk_fall) begin
            if (!r_ack_ph) begin
              w_sda_drv_nxt   = 1'b1;
              w_busy_nxt      = 1'b1;
              w_nack_seen_nxt = 1'b0;
              w_ack_ph_nxt    = 1'b1;
              w_byte_idx_nxt  = 2'd0;
              if (r_rw) begin
                w_shadow_nxt = tx_data;
              end
            end else begin
              w_ack_ph_nxt = 1'b0;
              if (r_rw) begin
                // First read bit goes out on the fall that ends the ACK
                w_state_nxt   = S_RD_BYTE;
                w_sda_drv_nxt = ~r_shadow[15];
                w_shadow_nxt  = {r_shadow[14:0], 1'b0};
                w_bit_cnt_nxt = 4'd1;
              end else begin
                w_state_nxt   = S_WR_BYTE;
                w_sda_drv_nxt = 1'b0;
                w_bit_cnt_nxt = 4'd0;
              end
            end
          end
        end

        S_WR_BYTE: begin
          if (w_sclk_rise) begin
            w_shift_nxt   = {r_shift[6:0], w_sda_f};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_bit_cnt_nxt = 4'd0;
              w_ack_ph_nxt  = 1'b0;
              w_state_nxt   = S_ACK_WR;
            end
          end
        end

        S_ACK_WR: begin
          if (w_sclk_fall) begin
            if (!r_ack_ph) begin
              if (r_byte_idx < 2'd2) begin
                w_sda_drv_nxt = 1'b1;
                w_ack_ph_nxt  = 1'b1;
              end else begin
                // Bytes past the second are refused and dropped
                w_sda_drv_nxt = 1'b0;
                w_state_nxt   = S_WAIT_STOP;
              end
            end else begin
              w_sda_drv_nxt = 1'b0;
              w_ack_ph_nxt  = 1'b0;
              if (r_byte_idx == 2'd0) begin
                w_rx_hi_nxt    = r_shift;
                w_byte_idx_nxt = 2'd1;
                w_state_nxt    = S_WR_BYTE;
              end else begin
                w_rx_data_nxt  = {r_rx_hi, r_shift};
                w_rx_valid_nxt = 1'b1;
                w_byte_idx_nxt = 2'd2;
                w_state_nxt    = S_WAIT_STOP;
              end
            end
          end
        end

        S_RD_BYTE: begin
          if (w_sclk_fall) begin
            if (r_bit_cnt == 4'd8) begin
              // Release for the master's ACK/NACK slot
              w_sda_drv_nxt = 1'b0;
              w_bit_cnt_nxt = 4'd0;
              w_state_nxt   = S_ACK_RD;
            end else begin
              w_sda_drv_nxt = ~r_shadow[15];
              w_shadow_nxt  = {r_shadow[14:0], 1'b0};
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end
          end
        end

        S_ACK_RD: begin
          if (w_sclk_rise) begin
            if (r_byte_idx == 2'd0 && !w_sda_f) begin
              w_byte_idx_nxt = 2'd1;
              w_bit_cnt_nxt  = 4'd0;
              w_state_nxt    = S_RD_BYTE;
            end else if (r_byte_idx == 2'd0) begin
              w_nack_seen_nxt = 1'b1;
              w_state_nxt     = S_WAIT_STOP;
            end else begin
              w_state_nxt = S_WAIT_STOP;
            end
          end
        end

        S_WAIT_STOP: begin
          w_sda_drv_nxt = 1'b0;
        end

        default: begin
          w_state_nxt   = S_IDLE;
          w_sda_drv_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: an open-drain bus master model drives
// directed transactions; expected values go into queues and a monitor
// compares them against what the DUT and the bus present.
module tb_i2c_slave_responder;

  localparam int HP = 10;  // sclk half period in clk cycles
  localparam int Q  = 5;   // offset of data changes / sampling inside a phase

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b1;
  logic        m_drv = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  wire         sda;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        done;
  logic        nack_seen;

  assign sda = m_drv ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_responder #(
    .SLAVE_ADDR (7'h27),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .sda      (sda),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .done     (done),
    .nack_seen(nack_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t        q_exp[$];
  logic [15:0] q_obs[$];
  logic [15:0] q_rx[$];
  logic        q_done[$];
  int          errors = 0;
  int          checks = 0;
  int          busy_cnt = 0;
  exp_t        mon_e;
  logic [15:0] mon_o;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT or the bus presents a value
  always @(negedge clk) begin
    if (busy) busy_cnt = busy_cnt + 1;
    if (rx_valid) begin
      if (q_rx.size() == 0) chk("rx_valid_unexpected", {15'd0, rx_valid}, 16'd0);
      else chk("rx_data", rx_data, q_rx.pop_front());
    end
    if (done) begin
      if (q_done.size() == 0) chk("done_unexpected", {15'd0, done}, 16'd0);
      else begin
        chk("done_nack_seen", {15'd0, nack_seen}, {15'd0, q_done.pop_front()});
        chk("done_busy", {15'd0, busy}, 16'd0);
      end
    end
    while (q_obs.size() > 0) begin
      mon_o = q_obs.pop_front();
      if (q_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL obs_unexpected: got %h expected nothing", mon_o);
      end else begin
        mon_e = q_exp.pop_front();
        chk(mon_e.name, mon_o, mon_e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ex(input string n, input logic [15:0] v);
    q_exp.push_back('{name: n, val: v});
  endtask

  task automatic ob(input logic [15:0] v);
    q_obs.push_back(v);
  endtask

  // Bus idle (sclk high, sda released) -> START, ends with sclk just low
  task automatic start_c();
    m_drv = 1'b0; sclk = 1'b1; tick(HP);
    m_drv = 1'b1; tick(HP);
    sclk = 1'b0;
  endtask

  task automatic stop_c();
    tick(Q); m_drv = 1'b1;
    tick(Q); sclk = 1'b1;
    tick(HP); m_drv = 1'b0;
    tick(HP);
  endtask

  task automatic send_bit(input logic b);
    tick(Q); m_drv = ~b;
    tick(Q); sclk = 1'b1;
    tick(HP); sclk = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    tick(Q); m_drv = 1'b0;
    tick(Q); sclk = 1'b1;
    tick(Q); b = sda;
    tick(Q); sclk = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic rd_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    logic [7:0] b;
    int         bc0;

    // Reset state
    #1 rst = 1'b0;
    tick(4);
    ex("rst_rx_data", 16'h0000);   ob(rx_data);
    ex("rst_busy", 16'h0000);      ob({15'd0, busy});
    ex("rst_rx_valid", 16'h0000);  ob({15'd0, rx_valid});
    ex("rst_done", 16'h0000);      ob({15'd0, done});
    ex("rst_nack", 16'h0000);      ob({15'd0, nack_seen});
    ex("rst_sda", 16'h0001);       ob({15'd0, sda});
    rst = 1'b1;
    tick(4);

    // Two-byte write to our address
    ex("t1_ack_addr", 16'h0000); ex("t1_ack_b0", 16'h0000); ex("t1_ack_b1", 16'h0000);
    q_rx.push_back(16'hA53C);
    q_done.push_back(1'b0);
    start_c();
    wr_byte(8'h4E, a); ob({15'd0, a});
    wr_byte(8'hA5, a); ob({15'd0, a});
    wr_byte(8'h3C, a); ob({15'd0, a});
    stop_c(); tick(8);
    ex("t1_busy_after", 16'h0000); ob({15'd0, busy});

    // Other address: never ACKed, nothing happens
    bc0 = busy_cnt;
    ex("t2_ack_addr", 16'h0001); ex("t2_ack_b0", 16'h0001);
    start_c();
    wr_byte(8'h50, a); ob({15'd0, a});
    wr_byte(8'h11, a); ob({15'd0, a});
    stop_c(); tick(8);
    ex("t2_busy_cycles", 16'h0000); ob(16'(busy_cnt - bc0));
    ex("t2_rx_hold", 16'hA53C);     ob(rx_data);

    // Read 0xBEEF; tx_data changes after the match to prove it was latched
    tx_data = 16'hBEEF;
    ex("t3_ack_addr", 16'h0000); ex("t3_byte0", 16'h00BE); ex("t3_byte1", 16'h00EF);
    ex("t3_released", 16'h0001);
    q_done.push_back(1'b0);
    start_c();
    wr_byte(8'h4F, a); ob({15'd0, a});
    tx_data = 16'h0000;
    rd_byte(b); ob({8'd0, b});
    send_bit(1'b0);
    rd_byte(b); ob({8'd0, b});
    send_bit(1'b1);
    read_bit(a); ob({15'd0, a});
    stop_c(); tick(8);

    // Read with NACK after byte0
    tx_data = 16'h1234;
    ex("t4_ack_addr", 16'h0000); ex("t4_byte0", 16'h0012); ex("t4_nack_seen", 16'h0001);
    ex("t4_tail_byte", 16'h00FF); ex("t4_tail_bit", 16'h0001);
    q_done.push_back(1'b1);
    start_c();
    wr_byte(8'h4F, a); ob({15'd0, a});
    rd_byte(b); ob({8'd0, b});
    send_bit(1'b1);
    ob({15'd0, nack_seen});
    rd_byte(b); ob({8'd0, b});
    read_bit(a); ob({15'd0, a});
    stop_c(); tick(8);

    // Three-byte write: third byte refused
    ex("t5_ack_addr", 16'h0000); ex("t5_ack_b0", 16'h0000); ex("t5_ack_b1", 16'h0000);
    ex("t5_ack_b2", 16'h0001);
    q_rx.push_back(16'h0102);
    q_done.push_back(1'b0);
    start_c();
    wr_byte(8'h4E, a); ob({15'd0, a});
    wr_byte(8'h01, a); ob({15'd0, a});
    wr_byte(8'h02, a); ob({15'd0, a});
    wr_byte(8'h03, a); ob({15'd0, a});
    stop_c(); tick(8);

    // Reset while the slave pulls sda low during a read
    tx_data = 16'h1234;
    ex("t6_ack_addr", 16'h0000); ex("t6_slave_low", 16'h0000);
    ex("t6_sda_on_reset", 16'h0001); ex("t6_rx_data", 16'h0000);
    ex("t6_busy", 16'h0000); ex("t6_nack", 16'h0000);
    ex("t6_done", 16'h0000); ex("t6_rx_valid", 16'h0000);
    start_c();
    wr_byte(8'h4F, a); ob({15'd0, a});
    tick(Q + 2);
    ob({15'd0, sda});
    #2 rst = 1'b0;
    #1 ob({15'd0, sda});
    ob(rx_data); ob({15'd0, busy}); ob({15'd0, nack_seen});
    ob({15'd0, done}); ob({15'd0, rx_valid});
    tick(2); rst = 1'b1; tick(2);
    stop_c(); tick(4);

    // Normal write after the reset
    ex("t7_ack_addr", 16'h0000); ex("t7_ack_b0", 16'h0000); ex("t7_ack_b1", 16'h0000);
    q_rx.push_back(16'h55AA);
    q_done.push_back(1'b0);
    start_c();
    wr_byte(8'h4E, a); ob({15'd0, a});
    wr_byte(8'h55, a); ob({15'd0, a});
    wr_byte(8'hAA, a); ob({15'd0, a});
    stop_c(); tick(20);

    chk("pending_bus_exp", 16'(q_exp.size()), 16'd0);
    chk("pending_rx_exp", 16'(q_rx.size()), 16'd0);
    chk("pending_done_exp", 16'(q_done.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C target (responder) for the two-byte write / two-byte read traffic our bus driver produces, i.e. the far end of that driver.
- Oversamples sclk/sda on the system clock, detects START/STOP, and matches the 7-bit address.
- Write: receives a 16-bit word. Read: returns a 16-bit word.
- Drives sda open-drain (low or release only). Sits between the I2C pins and a local register interface.

Parameters:
- SLAVE_ADDR, 7'h27, 7-bit address this block ACKs.
- SYNC_STAGES, 2, synchronizer flops on sclk and sda (min 2).

Ports:
- clk  input  1  system clock; sclk high/low phases must each be >= 4 clk periods (6 with filter).
- rst  input  1  asynchronous, active-low reset.
- sclk  input  1  I2C clock from the bus master.
- sda  inout  1  I2C data; driven 0 when sda_drv=1, else high-Z (bus pull-up gives 1).
- tx_data  input  16  read-back word; latched on address match with R/W=1.
- rx_data  output  16  last complete write word; byte0 in [15:8], byte1 in [7:0].
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high from address match until STOP or a new START.
- done  output  1  one-cycle pulse at STOP ending an addressed transaction.
- nack_seen  output  1  sticky; set when the master NACKs byte0 of a read; cleared at the next address match.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, sda_drv=0 (sda released immediately), rx_data=0.
  - rx_valid=0, busy=0, done=0, nack_seen=0, shift/bit counters=0.
- Bus sampling: sclk and sda pass through SYNC_STAGES flops. Edges are taken from the last two synchronized samples.
- Line events:
  - START = sda fall while sclk high. STOP = sda rise while sclk high.
  - Data is sampled on sclk rise.
  - sda_drv updates only on the first clk after a detected sclk fall.
- START (including repeated START) in any state -> ADDR: bit counter cleared, sda_drv=0, busy=0.
- STOP in any state -> IDLE, sda_drv=0. done pulses if busy was 1; busy=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first (7 address bits + R/W) on sclk rises. After the 8th rise:
    - match -> ACK_ADDR.
    - mismatch -> WAIT_STOP with sda never driven.
  - ACK_ADDR:
    - At the sclk fall after bit 8: sda_drv=1, busy=1, nack_seen=0. On R/W=1, tx_data is latched into a 16-bit shadow.
    - At the next fall: R/W=0 -> WR_BYTE with sda_drv=0; R/W=1 -> RD_BYTE driving shadow[15].
  - WR_BYTE: shift 8 bits; after the 8th rise -> ACK_WR.
  - ACK_WR: drive ACK for one sclk high phase. Byte index tracking:
    - byte 0: store in [15:8].
    - byte 1: store in [7:0]. rx_data and rx_valid update on the clk after the ACK-ending sclk fall, then -> WAIT_STOP.
    - byte >= 2: not ACKed (sda_drv stays 0), data discarded, -> WAIT_STOP.
  - RD_BYTE: on each sclk fall, sda_drv = ~shadow bit (MSB first). After the 8th bit's fall, sda_drv=0 -> ACK_RD.
  - ACK_RD: sample the master's bit on sclk rise.
    - byte0 with ACK (0) -> RD_BYTE for byte1.
    - byte0 with NACK (1) -> nack_seen=1, -> WAIT_STOP.
    - byte1 with either value -> WAIT_STOP.
  - WAIT_STOP: sda released; ignore all bits until STOP or START.
- Simultaneous START/STOP detection with a data edge: START/STOP take priority over bit shifting.
- Reset mid-transfer: sda released asynchronously. After release, the block waits for a fresh START; the partial transaction is never completed.
- Timing latency: pin change to internal edge detect is SYNC_STAGES+1 clk.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows the synchronizers on sclk and sda. Edge/event detect latency rises by 2 clk; pulses of 1 clk width are suppressed.
- Undefined: no filter; synchronizer outputs feed edge detection directly.

Test Plan:
- Write addr 0x27 W, bytes 0xA5, 0x3C, STOP -> sda=0 in all three ACK slots; rx_data=16'hA53C; one rx_valid pulse; done pulses once after STOP; busy=0 afterwards.
- Addr 0x28 W, byte 0x11 -> sda reads 1 in every ACK slot; rx_valid/busy/done never assert; rx_data unchanged.
- tx_data=16'hBEEF, addr 0x27 R, master ACK byte0, NACK byte1, STOP -> master samples 0xBE then 0xEF; sda released after byte1; nack_seen=0; done pulses.
- tx_data=16'h1234, read with master NACK after byte0 -> master gets 0x12; nack_seen=1; sda stays 1 for the following 9 clocks; done pulses at STOP.
- Write 0x27 W with 0x01, 0x02, 0x03 -> first two ACKed, third slot sda=1; rx_data=16'h0102 with exactly one rx_valid.
- Assert rst low while slave drives a 0 data bit during a read -> sda reads 1 in the same clk; all outputs zero; a following 0x27 write works normally.
